div_arbiter: RTL
================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req0_valid/req1_valid  in  1  divide request from issue pipe 0 / pipe 1.
REQ-005 SHALL have ports req0_op/req1_op  in  2  opcode: 0 div, 1 divu, 2 mod, 3 modu.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  in  XLEN  dividend, divisor.
REQ-007 SHALL have ports req0_rd/req1_rd  in  5  destination register.
REQ-008 SHALL have ports grant0/grant1  out  1  request accepted this cycle (combinational).
REQ-009 SHALL have port flush  in  1  pipeline flush; kills any in-flight or new operation.
REQ-010 SHALL have ports div_start out 1, div_op out 2, div_a out XLEN, div_b out XLEN  to the shared iterative divider.
REQ-011 SHALL have ports div_done in 1, div_res in XLEN  completion pulse and op-selected result.
REQ-012 SHALL have ports wb_valid out 1, wb_port out 1, wb_rd out 5, wb_data out XLEN  writeback to the granted pipe.
REQ-013 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, START, WAIT, DRAIN, WB.
REQ-015 IDLE: grant only when !flush and a request is valid; at most one grant per cycle; latch op/a/b/rd/port on grant.
REQ-016 IDLE->START on grant with b!=0; IDLE->WB on grant with b==0 (divider bypassed, wb_data=0).
REQ-017 START: div_start=1 for exactly one cycle, div_op/a/b from latches -> WAIT.
REQ-018 WAIT: on div_done latch div_res -> WB; div_a/b/op held stable until div_done.
REQ-019 WB: wb_valid=1 one cycle with latched port/rd/data -> IDLE; no grant in the same cycle.
REQ-020 Latency: grant cycle T, div_start T+1, div_done T+1+N, wb_valid T+2+N; zero-divisor wb_valid T+1.
REQ-021 flush in START -> IDLE, div_start not asserted; flush in WAIT without div_done -> DRAIN; flush in WAIT with div_done -> IDLE, result discarded; flush in WB -> wb_valid suppressed, -> IDLE.
REQ-022 DRAIN: ignore flush, wait for div_done, discard result -> IDLE; grants blocked.
REQ-023 grant0/grant1 SHALL be 0 in every state except IDLE.
REQ-024 div_done outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-025 On rst: state IDLE, all latches 0, last-grant pointer 1 (pipe 0 favoured next).
REQ-026 Outputs during/after reset: grant0/1, div_start, wb_valid, busy = 0; div_op/a/b, wb_port/rd/data = 0.
REQ-027 Reset mid-operation SHALL abandon the operation; a later div_done is ignored per REQ-024.

Configuration
REQ-028 Macro DIV_ARB_RR_EN defined: simultaneous requests granted round-robin, favouring the pipe not granted last; pointer updates on every grant.
REQ-029 Macro undefined: fixed priority, pipe 0 always wins; pointer logic absent.

Structure
REQ-030 Opcode encodings, state encoding and XLEN default SHALL live in shared package cpu_pkg.
REQ-031 The arbitration pick SHALL be one sub-module div_rr_pick (inputs req0/req1, last; outputs grant0/grant1).

Verification
REQ-032 Single req0: divu a=100 b=7, divider N=4 -> grant0 at T, div_start T+1, wb_valid T+6, wb_port=0, wb_data=14.
REQ-033 Zero divisor: req1 mod a=5 b=0 -> grant1, no div_start, wb_valid next cycle, wb_data=0, wb_port=1.
REQ-034 Simultaneous req0/req1 held for three operations, DIV_ARB_RR_EN defined -> grant order 0,1,0; undefined -> 0,0,0.
REQ-035 flush in WAIT two cycles before div_done -> DRAIN, no wb_valid, busy falls cycle after div_done, then new grant accepted.
REQ-036 rst asserted in WAIT, stray div_done after release -> state IDLE, no wb_valid, all outputs 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divide opcodes, divide-arbiter state encoding and default XLEN.
package cpu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_MOD  = 2'd2,
        OP_MODU = 2'd3
    } div_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_WB    = 3'd4
    } div_arb_state_e;

endpackage

// File: rtl/div_rr_pick.sv
// Two-way arbitration pick for the shared divider.
// DIV_ARB_RR_EN selects round-robin on contention; otherwise pipe 0 always wins.
module div_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant0,
    output logic grant1
);

`ifdef DIV_ARB_RR_EN
    // last==1 means pipe 1 was granted most recently, so pipe 0 wins a tie.
    always_comb begin
        grant0 = req0 && (!req1 || last);
        grant1 = req1 && (!req0 || !last);
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        grant0 = req0;
        grant1 = req1 && !req0;
    end
`endif

endmodule

// File: rtl/div_arbiter.sv
// Arbitrates two issue pipes onto one iterative divider and writes the result back.
// DIV_ARB_RR_EN defined: round-robin on simultaneous requests; undefined: pipe 0 priority.
module div_arbiter
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [1:0]      req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [4:0]      req0_rd,
    input  logic            req1_valid,
    input  logic [1:0]      req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [4:0]      req1_rd,
    output logic            grant0,
    output logic            grant1,
    input  logic            flush,
    output logic            div_start,
    output logic [1:0]      div_op,
    output logic [XLEN-1:0] div_a,
    output logic [XLEN-1:0] div_b,
    input  logic            div_done,
    input  logic [XLEN-1:0] div_res,
    output logic            wb_valid,
    output logic            wb_port,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            busy
);

    div_arb_state_e  state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [4:0]      rd_q, rd_d;
    logic            port_q, port_d;
    logic            last_q;
    logic            can_grant;

    // Grants are held low while reset is asserted, not just after it.
    assign can_grant = (state_q == S_IDLE) && !flush && !rst;

    div_rr_pick u_pick (
        .req0   (req0_valid && can_grant),
        .req1   (req1_valid && can_grant),
        .last   (last_q),
        .grant0 (grant0),
        .grant1 (grant1)
    );

`ifdef DIV_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (grant0 || grant1) begin
            last_q <= grant1;
        end
    end
`else
    assign last_q = 1'b1;
`endif

    // NOTE: state and latches use non-blocking assignments; reset is asynchronous so outputs clear immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            port_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            port_q  <= port_d;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        rd_d      = rd_q;
        port_d    = port_q;
        div_start = 1'b0;
        wb_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    port_d = grant1;
                    op_d   = grant1 ? req1_op : req0_op;
                    a_d    = grant1 ? req1_a  : req0_a;
                    b_d    = grant1 ? req1_b  : req0_b;
                    rd_d   = grant1 ? req1_rd : req0_rd;
                    if (b_d == '0) begin
                        data_d  = '0;
                        state_d = S_WB;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    div_start = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (div_done) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        data_d  = div_res;
                        state_d = S_WB;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (div_done) begin
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                wb_valid = !flush;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign div_op  = op_q;
    assign div_a   = a_q;
    assign div_b   = b_q;
    assign wb_port = port_q;
    assign wb_rd   = rd_q;
    assign wb_data = data_q;
    assign busy    = (state_q != S_IDLE);

endmodule
